mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds on the CPU's data-memory port (`Address`/`DataWr`/`DMWr`/`DMCtrl`/`DataRd`) as a peripheral target. Stores written bytes in a small FIFO and serializes them 8N1 on `tx`. The top level decodes `mmio_sel` to steer `DataRd` and to suppress the `DataMemory` write for this address window. Reads are combinational, matching the single-cycle datapath; writes take effect on the clock edge.

---
 rtl/mmio_uart_tx_pkg.sv | 39 +++
 rtl/mmio_uart_tx_if.sv | 19 +
 rtl/mmio_uart_tx_sync_fifo.sv | 59 +++++
 rtl/mmio_uart_tx.sv | 154 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants, register map and serializer state type for the MMIO UART TX.
package mmio_pkg;

  localparam logic [2:0] TXDATA_OFS = 3'd0;
  localparam logic [2:0] STATUS_OFS = 3'd4;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Assemble the STATUS register word; unused bits read as zero.
  function automatic logic [31:0] pack_status(
    input logic                full,
    input logic                empty,
    input logic                busy,
    input logic                ovf,
    input logic [ST_CNT_W-1:0] cnt
  );
    logic [31:0] s;
    s = '0;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_BUSY]  = busy;
    s[ST_OVF]   = ovf;
    s[ST_CNT_LSB +: ST_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory port as seen by the UART peripheral.
interface mmio_uart_tx_if;
  logic [31:0] Address;
  logic [31:0] DataWr;
  logic        DMWr;
  logic [2:0]  DMCtrl;
  logic        mmio_sel;
  logic [31:0] DataRd;

  modport master (
    output Address, DataWr, DMWr, DMCtrl,
    input  mmio_sel, DataRd
  );

  modport slave (
    input  Address, DataWr, DMWr, DMCtrl,
    output mmio_sel, DataRd
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO; push and pop may occur on the same edge, and a push
// into a full FIFO is accepted when a pop frees the slot on that edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and serializer.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  logic          sel;
  logic          reg_is_status;
  logic          push_req;
  logic          status_wr;
  logic          busy;
  logic          overflow;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_data;

  uart_state_t   state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          baud_end;

  // Store width and upper data bits are irrelevant to this peripheral.
  logic unused_bits;
  assign unused_bits = ^{bus.DMCtrl, bus.DataWr[31:8], bus.Address[1:0]};

  assign sel           = (bus.Address[31:3] == BASE_ADDR[31:3]);
  assign reg_is_status = (bus.Address[2] == STATUS_OFS[2]);
  assign push_req      = bus.DMWr && sel && !reg_is_status;
  assign status_wr     = bus.DMWr && sel && reg_is_status;
  assign busy          = (state != IDLE);
  assign baud_end      = (baud == BAUD_LAST);

  assign bus.mmio_sel = sel;
  assign bus.DataRd   = (sel && reg_is_status)
                        ? pack_status(fifo_full, fifo_empty, busy, overflow,
                                      ST_CNT_W'(fifo_count))
                        : '0;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_req),
    .pop     (fifo_pop),
    .wr_data (bus.DataWr[7:0]),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sticky overflow: set by a push the FIFO cannot take, cleared by any STATUS write.
  always_ff @(posedge clk) begin
    if (reset)                                   overflow <= 1'b0;
    else if (status_wr)                          overflow <= 1'b0;
    else if (push_req && fifo_full && !fifo_pop) overflow <= 1'b1;
  end

  // Serializer registers, including the registered tx line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // Next-state logic; tx is derived from the next state so the line
  // changes on the same edge the state does.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_n  = fifo_data;
          state_n  = START;
          baud_n   = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          baud_n    = '0;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_idx == 3'd7) state_n   = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_n  = fifo_data;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLK_DIV=4, FIFO_DEPTH=8.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned DIV  = 4;

  logic clk = 1'b0;
  logic reset;
  logic tx;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h", name, got, exp);
    end
  endtask

  task automatic peek(output logic [31:0] v);
    bus.Address = BASE + 32'd4;
    bus.DMWr    = 1'b0;
    #1;
    v = bus.DataRd;
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    bus.Address = addr;
    bus.DataWr  = data;
    bus.DMWr    = 1'b1;
    @(negedge clk);
    bus.DMWr    = 1'b0;
    bus.Address = '0;
  endtask

  // Samples tx once per cycle, starting at the current negedge, for n frames.
  task automatic check_frames(input logic [7:0] b0, input logic [7:0] b1,
                              input int unsigned n, input logic [31:0] mid_status);
    logic [9:0]  frame;
    logic [31:0] st;
    int unsigned f, bn;
    for (int unsigned i = 0; i < n * 10 * DIV; i++) begin
      f     = i / (10 * DIV);
      bn    = (i % (10 * DIV)) / DIV;
      frame = {1'b1, (f == 0) ? b0 : b1, 1'b0};
      check($sformatf("tx[%0d]", i), {31'b0, tx}, {31'b0, frame[bn]});
      if (i == 5 * DIV) begin
        peek(st);
        check("mid_sel", {31'b0, bus.mmio_sel}, 32'd1);
        check("mid_status", st, mid_status);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] st;
    logic        stayed_high;

    vecs[0] = '{32'h0000_1000, 1'b1, 32'h0000_0000};
    vecs[1] = '{32'h0000_1004, 1'b1, 32'h0000_0002};
    vecs[2] = '{32'h0000_1008, 1'b0, 32'h0000_0000};
    vecs[3] = '{32'h0000_0FFC, 1'b0, 32'h0000_0000};
    vecs[4] = '{32'h0000_1003, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'h0000_1007, 1'b1, 32'h0000_0002};
    vecs[6] = '{32'h8000_1004, 1'b0, 32'h0000_0000};
    vecs[7] = '{32'h0000_1005, 1'b1, 32'h0000_0002};

    reset       = 1'b1;
    bus.Address = '0;
    bus.DataWr  = '0;
    bus.DMWr    = 1'b0;
    bus.DMCtrl  = 3'b010;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and address decode at idle.
    check("reset_tx", {31'b0, tx}, 32'd1);
    for (int unsigned i = 0; i < 8; i++) begin
      bus.Address = vecs[i].addr;
      #1;
      check($sformatf("sel[%0d]", i), {31'b0, bus.mmio_sel}, {31'b0, vecs[i].exp_sel});
      check($sformatf("rd[%0d]", i), bus.DataRd, vecs[i].exp_rd);
    end

    // Single byte 0x55.
    @(negedge clk);
    write(BASE, 32'h0000_0055);
    check("pre_pop_tx", {31'b0, tx}, 32'd1);
    peek(st);
    check("pre_pop_status", st, 32'h0000_0010);
    @(negedge clk);
    check_frames(8'h55, 8'h00, 1, 32'h0000_0006);
    check("t1_idle_tx", {31'b0, tx}, 32'd1);
    peek(st);
    check("t1_status", st, 32'h0000_0002);

    // Two bytes on consecutive cycles: gapless frames.
    bus.Address = BASE;
    bus.DataWr  = 32'h0000_00A5;
    bus.DMWr    = 1'b1;
    @(negedge clk);
    bus.DataWr  = 32'h0000_003C;
    @(negedge clk);
    bus.DMWr    = 1'b0;
    check_frames(8'hA5, 8'h3C, 2, 32'h0000_0014);
    check("t2_idle_tx", {31'b0, tx}, 32'd1);
    peek(st);
    check("t2_status", st, 32'h0000_0002);

    // Ten pushes into an 8-deep FIFO while idle.
    bus.Address = BASE;
    bus.DMWr    = 1'b1;
    for (int unsigned k = 0; k < 10; k++) begin
      bus.DataWr = 32'(k + 1);
      @(negedge clk);
    end
    bus.DMWr = 1'b0;
    peek(st);
    check("ovf_status", st, 32'h0000_008D);
    write(BASE + 32'd4, 32'h0000_0000);
    peek(st);
    check("ovf_cleared", st, 32'h0000_0085);

    // Push while full on the edge the STOP bit ends and pops: accepted.
    repeat (30) @(negedge clk);
    write(BASE, 32'h0000_0077);
    peek(st);
    check("full_push_pop", st, 32'h0000_0085);
    check("full_push_pop_tx", {31'b0, tx}, 32'd0);

    // Reset in the middle of DATA bit 3 aborts the frame and flushes.
    repeat (17) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    peek(st);
    check("rst_status", st, 32'h0000_0002);
    reset = 1'b0;
    stayed_high = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) stayed_high = 1'b0;
    end
    check("rst_no_frames", {31'b0, stayed_high}, 32'd1);

    // Store outside the window: no select, no read data, no push.
    bus.Address = BASE + 32'd8;
    bus.DataWr  = 32'h0000_0012;
    bus.DMWr    = 1'b1;
    #1;
    check("out_sel", {31'b0, bus.mmio_sel}, 32'd0);
    check("out_rd", bus.DataRd, 32'd0);
    @(negedge clk);
    bus.DMWr = 1'b0;
    repeat (3) @(negedge clk);
    check("out_tx", {31'b0, tx}, 32'd1);
    peek(st);
    check("out_status", st, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
